// File: rtl/smash_pkg.sv
// Shared attack-word layout, per-class hit constants and hit FSM states.
// Pure declarations; no latency or flow control of its own.
package smash_pkg;

    localparam int BIT_HIT       = 0;
    localparam int BIT_SMASH_U   = 1;
    localparam int BIT_SMASH_R   = 4;
    localparam int BIT_JAB       = 5;
    localparam int BIT_SPECIAL_U = 6;
    localparam int BIT_SPECIAL_R = 9;
    localparam int BIT_SPECIAL_N = 10;
    localparam int BIT_ACTIVE    = 11;
    localparam int BIT_SHIELD    = 12;

    localparam logic [9:0] DAMAGE_MAX = 10'd999;

    localparam logic [4:0] DMG_SMASH   = 5'd15;
    localparam logic [4:0] DMG_SPECIAL = 5'd8;
    localparam logic [4:0] DMG_NEUTRAL = 5'd5;
    localparam logic [4:0] DMG_JAB     = 5'd3;
    localparam logic [4:0] DMG_NONE    = 5'd0;

    localparam logic [7:0] STUN_SMASH   = 8'd30;
    localparam logic [7:0] STUN_SPECIAL = 8'd20;
    localparam logic [7:0] STUN_NEUTRAL = 8'd10;
    localparam logic [7:0] STUN_JAB     = 8'd10;
    localparam logic [7:0] STUN_NONE    = 8'd10;

    typedef enum logic [1:0] {IDLE, CAPTURE, STUN} hitState_t;

    typedef struct packed {
        logic [4:0] dmg;
        logic [7:0] stun;
    } hitClass_t;

    // Takes attack bits [10:1]; the lowest set bit decides the class.
    function automatic hitClass_t classify(input logic [9:0] kind);
        hitClass_t c;
        if (|kind[BIT_SMASH_R-1:BIT_SMASH_U-1]) begin
            c.dmg = DMG_SMASH;   c.stun = STUN_SMASH;
        end else if (kind[BIT_JAB-1]) begin
            c.dmg = DMG_JAB;     c.stun = STUN_JAB;
        end else if (|kind[BIT_SPECIAL_R-1:BIT_SPECIAL_U-1]) begin
            c.dmg = DMG_SPECIAL; c.stun = STUN_SPECIAL;
        end else if (kind[BIT_SPECIAL_N-1]) begin
            c.dmg = DMG_NEUTRAL; c.stun = STUN_NEUTRAL;
        end else begin
            c.dmg = DMG_NONE;    c.stun = STUN_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_ticker.sv
// Free-running frame prescaler: one-cycle tick every FRAME_DIV clocks.
// Tick on count FRAME_DIV-1, first one FRAME_DIV-1 cycles after reset.
// No backpressure; always counting.
module frame_ticker #(
    parameter int FRAME_DIV = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int CW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(FRAME_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/hit_receiver.sv
// Victim side of a hit: registers each landed attack once, accumulates damage,
// produces damage-scaled decaying knockback and hitstun. hit_ack one cycle after
// hit rises; velocity/stunned one cycle later. No backpressure; inputs sampled every cycle.
module hit_receiver
    import smash_pkg::*;
#(
    parameter int FRAME_DIV = 833333,
    parameter int DECAY     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] opp_attack,
    input  logic [31:0] opp_knockback,
    input  logic        own_shield,
    input  logic        clear_damage,
    output logic [15:0] damage,
    output logic [31:0] velocity,
    output logic        stunned,
    output logic        hit_ack
);
    localparam logic signed [15:0] DEC = 16'(DECAY);

    hitState_t         state, stateNext;
    logic              frameTick;
    logic              armed;
    logic              detect, accept;
    logic [9:0]        dmgReg;
    logic [10:0]       dmgSum;
    logic [9:0]        dmgSat;
    logic [7:0]        baseStun, stunCnt;
    logic [8:0]        stunSum;
    logic [7:0]        stunInit;
    logic signed [15:0] velX, velY;
    hitClass_t         cls;
    logic              unusedBits;

    frame_ticker #(.FRAME_DIV(FRAME_DIV)) ticker (
        .clock (clock),
        .reset (reset),
        .tick  (frameTick)
    );

    assign unusedBits = ^{opp_attack[31:BIT_SHIELD]};

    assign cls    = classify(opp_attack[BIT_SPECIAL_N:BIT_SMASH_U]);
    assign detect = armed & opp_attack[BIT_HIT];
    assign accept = detect & ~own_shield & ~clear_damage;

    assign dmgSum = {1'b0, dmgReg} + {6'b0, cls.dmg};
    assign dmgSat = (dmgSum > {1'b0, DAMAGE_MAX}) ? DAMAGE_MAX : dmgSum[9:0];

    // dmgReg already holds the new damage by the CAPTURE cycle.
    assign stunSum  = {1'b0, baseStun} + {3'b0, dmgReg[9:4]};
    assign stunInit = stunSum[8] ? 8'd255 : stunSum[7:0];

    function automatic logic signed [15:0] scaleAxis(input logic signed [15:0] k,
                                                     input logic [9:0] d);
        logic signed [26:0] kx, dx, prod, sum;
        kx   = 27'(k);
        dx   = 27'($signed({1'b0, d}));
        prod = kx * dx;
        sum  = kx + (prod >>> 7);
        if (sum > 27'sd32767)        return 16'sh7FFF;
        else if (sum < -27'sd32768)  return 16'sh8000;
        else                         return sum[15:0];
    endfunction

    function automatic logic signed [15:0] decayAxis(input logic signed [15:0] v);
        if (v > DEC)       return v - DEC;
        else if (v < -DEC) return v + DEC;
        else               return 16'sd0;
    endfunction

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = CAPTURE;
            CAPTURE: stateNext = STUN;
            STUN: begin
                if (accept)                           stateNext = CAPTURE;
                else if (frameTick && stunCnt <= 8'd1) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (clear_damage) stateNext = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            armed    <= 1'b0;
            dmgReg   <= '0;
            baseStun <= '0;
            stunCnt  <= '0;
            velX     <= '0;
            velY     <= '0;
        end else begin
            state <= stateNext;

            if (clear_damage || detect)         armed <= 1'b0;
            else if (!opp_attack[BIT_ACTIVE])   armed <= 1'b1;

            if (clear_damage)  dmgReg <= '0;
            else if (accept)   dmgReg <= dmgSat;

            if (accept) baseStun <= cls.stun;

            if (clear_damage) begin
                velX <= '0;
                velY <= '0;
            end else if (state == CAPTURE) begin
                velX    <= scaleAxis(opp_knockback[31:16], dmgReg);
                velY    <= scaleAxis(opp_knockback[15:0], dmgReg);
                stunCnt <= stunInit;
            end else if (state == STUN && frameTick) begin
                if (stunCnt <= 8'd1) begin
                    stunCnt <= '0;
                    velX    <= '0;
                    velY    <= '0;
                end else begin
                    stunCnt <= stunCnt - 8'd1;
                    velX    <= decayAxis(velX);
                    velY    <= decayAxis(velY);
                end
            end
        end
    end

    assign damage   = {6'b0, dmgReg};
    assign velocity = {velX, velY};
    assign stunned  = (state == STUN);
    assign hit_ack  = (state == CAPTURE) & ~clear_damage;

endmodule
